// File: rtl/core_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with trap on
// illegal opcodes or memory timeouts, plus a retired-instruction counter.
module core_seq_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_ack,
    input  logic [6:0]       inst_opcode,
    input  logic             w_en,
    input  logic             mw_en,
    input  logic             maddr_sel,
    input  logic             jump_en,
    input  logic             branch_taken,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_en,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             trap,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd7;

    // Wait counter holds 0 .. MEM_TIMEOUT-1 (request cycle index minus one)
    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic [CNT_W-1:0]  instret_q;
    logic              opcode_legal;
    logic              wait_last;

    // Opcodes accepted by the core (R, I-ALU, load, store, branch, custom-0)
    always_comb begin
        opcode_legal = 1'b0;
        case (inst_opcode)
            7'b0110011,
            7'b0010011,
            7'b0000011,
            7'b0100011,
            7'b1100011,
            7'b0001011: opcode_legal = 1'b1;
            default:    opcode_legal = 1'b0;
        endcase
    end

    assign wait_last = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    // Next-state and strobe decode; wait counter stays zero outside request states
    always_comb begin
        state_d  = state_q;
        wait_d   = '0;
        imem_req = 1'b0;
        ir_en    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = 1'b0;
        trap     = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_en   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_last) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                state_d = opcode_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (jump_en) begin
                    pc_en   = 1'b1;
                    pc_sel  = branch_taken;
                    state_d = S_FETCH;
                end else if (mw_en || maddr_sel) begin
                    state_d = S_MEM;
                end else if (w_en) begin
                    state_d = S_WB;
                end else begin
                    pc_en   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mw_en;
                if (dmem_ack) begin
                    // Store wins when both store and load flags are set
                    if (mw_en) begin
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_last) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_en   = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        // Reset abandons any request and suppresses every strobe immediately
        if (rst) begin
            imem_req = 1'b0;
            ir_en    = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            rf_we    = 1'b0;
            pc_en    = 1'b0;
            pc_sel   = 1'b0;
            trap     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (pc_en) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: walks each instruction class, timeout,
// trap and reset cases with hand-computed state/strobe expectations.
module tb_core_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_ack;
    logic [6:0]  inst_opcode;
    logic        w_en;
    logic        mw_en;
    logic        maddr_sel;
    logic        jump_en;
    logic        branch_taken;
    logic        dmem_ack;
    logic        imem_req;
    logic        ir_en;
    logic        dmem_req;
    logic        dmem_we;
    logic        rf_we;
    logic        pc_en;
    logic        pc_sel;
    logic        trap;
    logic [2:0]  state;
    logic [31:0] instret;
    logic [7:0]  strb;

    int checks = 0;
    int errors = 0;

    core_seq_ctrl #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_ack     (imem_ack),
        .inst_opcode  (inst_opcode),
        .w_en         (w_en),
        .mw_en        (mw_en),
        .maddr_sel    (maddr_sel),
        .jump_en      (jump_en),
        .branch_taken (branch_taken),
        .dmem_ack     (dmem_ack),
        .imem_req     (imem_req),
        .ir_en        (ir_en),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .rf_we        (rf_we),
        .pc_en        (pc_en),
        .pc_sel       (pc_sel),
        .trap         (trap),
        .state        (state),
        .instret      (instret)
    );

    // Strobe vector: {imem_req, ir_en, dmem_req, dmem_we, rf_we, pc_en, pc_sel, trap}
    assign strb = {imem_req, ir_en, dmem_req, dmem_we, rf_we, pc_en, pc_sel, trap};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [2:0] exp_state, input logic [7:0] exp_strb);
        #1;
        chk({tag, ".state"}, 32'(state), 32'(exp_state));
        chk({tag, ".strb"}, 32'(strb), 32'(exp_strb));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic [6:0] op, input logic w, input logic mw,
                           input logic ma, input logic j, input logic bt);
        inst_opcode  = op;
        w_en         = w;
        mw_en        = mw;
        maddr_sel    = ma;
        jump_en      = j;
        branch_taken = bt;
    endtask

    initial begin
        rst = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        set_dec(7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        cyc("reset", 3'd0, 8'h00);
        chk("reset.instret", instret, 32'd0);

        // R-type, ack on first fetch cycle
        rst = 1'b0;
        imem_ack = 1'b1;
        cyc("r.fetch", 3'd0, 8'hC0);
        tick();
        imem_ack = 1'b0;
        set_dec(7'b0110011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("r.dec", 3'd1, 8'h00);
        tick();
        cyc("r.exec", 3'd2, 8'h00);
        tick();
        cyc("r.wb", 3'd4, 8'h0C);
        chk("r.wb.instret", instret, 32'd0);
        tick();
        chk("r.instret", instret, 32'd1);

        // Load, ack on third MEM cycle; stray dmem_ack in DECODE is ignored
        imem_ack = 1'b1;
        cyc("ld.fetch", 3'd0, 8'hC0);
        tick();
        imem_ack = 1'b0;
        dmem_ack = 1'b1;
        set_dec(7'b0000011, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("ld.dec", 3'd1, 8'h00);
        tick();
        dmem_ack = 1'b0;
        cyc("ld.exec", 3'd2, 8'h00);
        tick();
        cyc("ld.mem1", 3'd3, 8'h20);
        tick();
        cyc("ld.mem2", 3'd3, 8'h20);
        tick();
        dmem_ack = 1'b1;
        cyc("ld.mem3", 3'd3, 8'h20);
        tick();
        dmem_ack = 1'b0;
        cyc("ld.wb", 3'd4, 8'h0C);
        tick();
        chk("ld.instret", instret, 32'd2);

        // Store, ack on first MEM cycle retires in that cycle
        imem_ack = 1'b1;
        cyc("st.fetch", 3'd0, 8'hC0);
        tick();
        imem_ack = 1'b0;
        set_dec(7'b0100011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("st.dec", 3'd1, 8'h00);
        tick();
        cyc("st.exec", 3'd2, 8'h00);
        tick();
        dmem_ack = 1'b1;
        cyc("st.mem", 3'd3, 8'h34);
        chk("st.mem.instret", instret, 32'd2);
        tick();
        dmem_ack = 1'b0;
        cyc("st.next", 3'd0, 8'h80);
        chk("st.instret", instret, 32'd3);

        // Branch taken, then not taken
        imem_ack = 1'b1;
        cyc("bt.fetch", 3'd0, 8'hC0);
        tick();
        imem_ack = 1'b0;
        set_dec(7'b1100011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("bt.dec", 3'd1, 8'h00);
        tick();
        cyc("bt.exec", 3'd2, 8'h06);
        tick();
        chk("bt.instret", instret, 32'd4);
        imem_ack = 1'b1;
        cyc("bn.fetch", 3'd0, 8'hC0);
        tick();
        imem_ack = 1'b0;
        set_dec(7'b1100011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("bn.dec", 3'd1, 8'h00);
        tick();
        cyc("bn.exec", 3'd2, 8'h04);
        tick();
        cyc("bn.next", 3'd0, 8'h80);
        chk("bn.instret", instret, 32'd5);

        // Store acked on the 16th (final) request cycle: ack wins over timeout
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        set_dec(7'b0100011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("stl.dec", 3'd1, 8'h00);
        tick();
        tick();
        for (int i = 1; i <= 15; i++) begin
            cyc("stl.wait", 3'd3, 8'h30);
            tick();
        end
        dmem_ack = 1'b1;
        cyc("stl.mem16", 3'd3, 8'h34);
        tick();
        dmem_ack = 1'b0;
        cyc("stl.next", 3'd0, 8'h80);
        chk("stl.instret", instret, 32'd6);

        // Custom-0 with no decoder flags retires straight from EXEC
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        set_dec(7'b0001011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        cyc("cu.exec", 3'd2, 8'h04);
        tick();
        chk("cu.instret", instret, 32'd7);

        // Illegal opcode traps and holds until reset
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        set_dec(7'b0110111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("il.dec", 3'd1, 8'h00);
        tick();
        imem_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc("il.trap", 3'd7, 8'h01);
            chk("il.instret", instret, 32'd7);
            tick();
        end
        imem_ack = 1'b0;
        rst = 1'b1;
        cyc("il.rst", 3'd7, 8'h00);
        tick();
        rst = 1'b0;
        cyc("il.after", 3'd0, 8'h80);
        chk("il.after.instret", instret, 32'd0);

        // Fetch timeout: imem_req high for exactly 16 cycles, then TRAP
        for (int i = 1; i <= 16; i++) begin
            cyc("to.fetch", 3'd0, 8'h80);
            tick();
        end
        cyc("to.trap", 3'd7, 8'h01);

        // Reset during MEM abandons the request at once
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        set_dec(7'b0010011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        cyc("rm.wb", 3'd4, 8'h0C);
        tick();
        chk("rm.pre.instret", instret, 32'd1);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        set_dec(7'b0000011, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        cyc("rm.mem", 3'd3, 8'h20);
        tick();
        rst = 1'b1;
        dmem_ack = 1'b1;
        cyc("rm.rst", 3'd3, 8'h00);
        tick();
        rst = 1'b0;
        dmem_ack = 1'b0;
        cyc("rm.after", 3'd0, 8'h80);
        chk("rm.instret", instret, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
Multi-cycle sequencer for the RV32 core: steps each instruction through FETCH, DECODE, EXEC, MEM and WB and produces all write/enable strobes (IR load, regfile write, dmem request, PC update). It consumes the instruction decoder's control outputs (w_en, mw_en, maddr_sel, jump_en) plus the branch comparator result, handshakes with instruction and data memory, and retires one instruction at a time. It traps on illegal opcodes and on memory timeouts, and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter
MEM_TIMEOUT, 16, max cycles a memory request may stay unacknowledged (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
imem_ack  in  1  instruction memory: data valid this cycle
inst_opcode  in  7  inst[6:0] of the instruction held in IR
w_en  in  1  decoder: instruction writes regfile
mw_en  in  1  decoder: store
maddr_sel  in  1  decoder: load
jump_en  in  1  decoder: branch instruction
branch_taken  in  1  branch comparator result
dmem_ack  in  1  data memory: access complete this cycle
imem_req  out  1  instruction fetch request
ir_en  out  1  load IR from imem data
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (valid with dmem_req)
rf_we  out  1  regfile write strobe
pc_en  out  1  PC update strobe (retire)
pc_sel  out  1  0: PC+4, 1: PC+branch offset (valid with pc_en)
trap  out  1  sticky error flag
state  out  3  current state encoding
instret  out  CNT_W  retired-instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Codes 5 and 6 are unused and go to TRAP.
- Outputs are decoded from state plus acks and are combinational. While rst=1, all strobes and trap are forced to 0. On the clock edge with rst=1: state<=FETCH, instret<=0, wait counter<=0.
- FETCH: imem_req=1. On imem_ack: ir_en=1 in the same cycle, next state DECODE.
- DECODE: legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 0001011. A legal opcode goes to EXEC; any other opcode goes to TRAP. No strobes in this state.
- EXEC, evaluated in priority order:
  - jump_en=1: pc_en=1, pc_sel=branch_taken, retire, next FETCH.
  - else mw_en or maddr_sel: next MEM.
  - else w_en: next WB.
  - else: pc_en=1, pc_sel=0, retire, next FETCH.
- MEM: dmem_req=1, dmem_we=mw_en. On dmem_ack, a store (mw_en=1) retires in that cycle with pc_en=1, pc_sel=0, next FETCH; a load goes to WB. If mw_en and maddr_sel are both 1, the instruction is treated as a store.
- WB: rf_we=1, pc_en=1, pc_sel=0, retire, next FETCH.
- TRAP: trap=1, all strobes 0. TRAP is held until rst.
- Retire: instret increments by 1 exactly on cycles where pc_en=1 and wraps modulo 2^CNT_W. There is no other update path.
- Timeout: the wait counter clears on entry to FETCH or MEM and increments each cycle the request is high without an ack. An ack in any of the first MEM_TIMEOUT request cycles is accepted. If there is no ack in request cycle MEM_TIMEOUT, next state is TRAP. If the ack and the final-cycle condition coincide, the ack wins.
- An ack arriving while its request is low is ignored.
- Reset mid-operation: any pending imem/dmem request is abandoned, with req dropping in the reset cycle. No rf_we or pc_en is issued, and FETCH restarts after reset deasserts.
- Latency with ack on the first request cycle:
  - R/I-ALU: 4 cycles.
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.

Test Plan:
1. R-type (opcode 0110011, w_en=1), imem_ack on first FETCH cycle -> states 0,1,2,4,0; rf_we=1 and pc_en=1 only in the WB cycle; instret 0->1.
2. Load (maddr_sel=1, w_en=1), dmem_ack on 3rd MEM cycle -> states 0,1,2,3,3,3,4; dmem_we=0 throughout; rf_we in WB; 7 cycles total; instret +1.
3. Store (mw_en=1), dmem_ack on 1st MEM cycle -> dmem_req=dmem_we=1 and pc_en=1 in the same cycle; rf_we never asserted; next state FETCH.
4. Branch (jump_en=1), first with branch_taken=1, then repeated with branch_taken=0 -> pc_en=1 in EXEC with pc_sel=1, then pc_sel=0; 3 cycles each; instret +2.
5. Illegal opcode 0110111 -> DECODE->TRAP, trap=1 held for 20 cycles, instret unchanged. Asserting rst for 1 cycle -> state=0, trap=0, instret=0.
6. imem_ack held low -> imem_req high for exactly 16 cycles, then state=7. Separately, rst asserted during MEM -> dmem_req=0 that cycle, state=0 next cycle, instret=0.
